// File: rtl/da_wave_monitor.sv
// da_wave_monitor: receive-side monitor for the square-wave DAC bus.
// Synchronizes DA_Clock/DA_Data into Sys_Clock, captures one sample per
// DA_Clock rising edge and classifies samples into high/low phases,
// reporting half-period length and plateau levels at each transition.
//
// Optional feature macro: DA_MON_CYCLE_COUNT_EN
//   defined   -> Half_Period_Clk reports Sys_Clock cycles per phase
//   undefined -> cycle counter not built, Half_Period_Clk tied to 0
//
// Output handshake: there is no ready/back-pressure. Sample_Valid and
// Meas_Valid are single-cycle pulses; their companion data outputs are
// registered with the pulse and hold until the next pulse of the same kind.
module da_wave_monitor #(
    parameter int Data_Width      = 14,
    parameter int Sync_Stages     = 2,
    parameter int Count_Width     = 16,
    parameter int Level_Threshold = 4,
    parameter int Timeout_Samples = 65535
) (
    input  logic                   Sys_Clock,
    input  logic                   nReset,
    input  logic                   DA_Clock,
    input  logic [Data_Width-1:0]  DA_Data,
    output logic                   Sample_Valid,
    output logic [Data_Width-1:0]  Sample_Data,
    output logic                   Meas_Valid,
    output logic [Count_Width-1:0] Half_Period,
    output logic [Data_Width-1:0]  High_Level,
    output logic [Data_Width-1:0]  Low_Level,
    output logic                   Timeout,
    output logic [Count_Width-1:0] Half_Period_Clk
);

    localparam int XW = Data_Width + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEEK = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    localparam logic [XW-1:0]          THRESH    = XW'(Level_Threshold);
    localparam logic [Count_Width-1:0] TO_LIMIT  = Count_Width'(Timeout_Samples);
    localparam logic [Count_Width-1:0] CNT_MAX   = '1;
    localparam logic [Count_Width-1:0] CNT_ONE   = Count_Width'(1);

    // Clock and data travel through identical chains so the data word
    // taken at the edge belongs to the same DA_Clock period.
    logic [Sync_Stages-1:0]                 clk_sync;
    logic [Sync_Stages-1:0][Data_Width-1:0] data_sync;
    logic                                   clk_prev;
    logic                                   capture;

    logic [1:0]             state;
    logic [Data_Width-1:0]  level;
    logic [Count_Width-1:0] cnt;
    logic [Count_Width-1:0] cnt_inc;
    logic                   timeout_hit;

    logic [XW-1:0] s_ext;
    logic [XW-1:0] l_ext;
    logic          up;
    logic          down;
    logic          enter_phase;
    logic          end_phase;

    assign capture = clk_sync[Sync_Stages-1] & ~clk_prev;

    // Synchronizer chains plus edge detector on the synchronized DA_Clock.
    always_ff @(posedge Sys_Clock or negedge nReset) begin
        if (!nReset) begin
            clk_sync  <= '0;
            data_sync <= '0;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[Sync_Stages-2:0], DA_Clock};
            data_sync <= {data_sync[Sync_Stages-2:0], DA_Data};
            clk_prev  <= clk_sync[Sync_Stages-1];
        end
    end

    // Sample capture: one registered word and pulse per DA_Clock edge.
    always_ff @(posedge Sys_Clock or negedge nReset) begin
        if (!nReset) begin
            Sample_Valid <= 1'b0;
            Sample_Data  <= '0;
        end else begin
            Sample_Valid <= capture;
            if (capture) begin
                Sample_Data <= data_sync[Sync_Stages-1];
            end
        end
    end

    // Classification of the freshly captured sample against the phase level.
    // Widened by one bit so L + threshold cannot wrap.
    always_comb begin
        s_ext       = {1'b0, Sample_Data};
        l_ext       = {1'b0, level};
        up          = s_ext > (l_ext + THRESH);
        down        = (s_ext + THRESH) < l_ext;
        cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        timeout_hit = cnt_inc >= TO_LIMIT;
        end_phase   = Sample_Valid &
                      (((state == ST_HIGH) && down) || ((state == ST_LOW) && up));
        enter_phase = end_phase |
                      (Sample_Valid && (state == ST_SEEK) && (up || down));
    end

    // Phase FSM and measurement registers; everything advances on a captured
    // sample, one cycle after Sample_Valid's data is available.
    always_ff @(posedge Sys_Clock or negedge nReset) begin
        if (!nReset) begin
            state       <= ST_IDLE;
            level       <= '0;
            cnt         <= '0;
            Meas_Valid  <= 1'b0;
            Half_Period <= '0;
            High_Level  <= '0;
            Low_Level   <= '0;
            Timeout     <= 1'b0;
        end else begin
            Meas_Valid <= end_phase;
            if (Sample_Valid) begin
                // Every state tracks the newest sample as the reference level.
                level <= Sample_Data;
                if (end_phase) begin
                    Half_Period <= cnt;
                    Timeout     <= 1'b0;
                    if (state == ST_HIGH) begin
                        High_Level <= level;
                    end else begin
                        Low_Level <= level;
                    end
                end
                if (enter_phase) begin
                    cnt   <= CNT_ONE;
                    state <= up ? ST_HIGH : ST_LOW;
                end else if (state == ST_IDLE) begin
                    state <= ST_SEEK;
                end else if ((state == ST_HIGH) || (state == ST_LOW)) begin
                    // Same-direction jumps land here: a level change, not a transition.
                    cnt <= cnt_inc;
                    if (timeout_hit) begin
                        Timeout <= 1'b1;
                        state   <= ST_SEEK;
                    end
                end
            end
        end
    end

`ifdef DA_MON_CYCLE_COUNT_EN
    logic [Count_Width-1:0] cyc_cnt;

    // Sys_Clock cycles since phase entry, latched with each measurement.
    always_ff @(posedge Sys_Clock or negedge nReset) begin
        if (!nReset) begin
            cyc_cnt         <= '0;
            Half_Period_Clk <= '0;
        end else begin
            if (enter_phase) begin
                cyc_cnt <= CNT_ONE;
            end else if (cyc_cnt != CNT_MAX) begin
                cyc_cnt <= cyc_cnt + CNT_ONE;
            end
            if (end_phase) begin
                Half_Period_Clk <= cyc_cnt;
            end
        end
    end
`else
    assign Half_Period_Clk = '0;
`endif

endmodule
